// File: rtl/pal_sync_gen_if.sv
// pal_sync_gen_if: pixel inputs and sync/video outputs of the PAL sync generator.
interface pal_sync_gen_if;
    logic       red_in;
    logic       green_in;
    logic       blue_in;
    logic       csync_out;
    logic       red_out;
    logic       green_out;
    logic       blue_out;
    logic       active_out;
    logic       field_odd;
    logic [9:0] line_num;

    modport master (
        output red_in, green_in, blue_in,
        input  csync_out, red_out, green_out, blue_out, active_out, field_odd, line_num
    );

    modport slave (
        input  red_in, green_in, blue_in,
        output csync_out, red_out, green_out, blue_out, active_out, field_odd, line_num
    );
endinterface

// File: rtl/pal_sync_gen.sv
// pal_sync_gen: interlaced 625-line PAL composite sync and gated 1-bit RGB generator.
// All timing derives from one hcount/line counter pair; every output is registered.
module pal_sync_gen #(
    parameter int H_TOTAL   = 5184,
    parameter int HSYNC_LEN = 381,
    parameter int EQ_LEN    = 190,
    parameter int BROAD_LEN = 2211,
    parameter int ACT_START = 851,
    parameter int ACT_LEN   = 4212
) (
    input  logic          clk,
    input  logic          reset_n,
    pal_sync_gen_if.slave vid
);
    localparam int HW = $clog2(H_TOTAL + 1);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_HALF = HW'(H_TOTAL / 2);
    localparam logic [HW-1:0] W_N    = HW'(HSYNC_LEN);
    localparam logic [HW-1:0] W_E    = HW'(EQ_LEN);
    localparam logic [HW-1:0] W_B    = HW'(BROAD_LEN);
    localparam logic [HW-1:0] A_BEG  = HW'(ACT_START);
    localparam logic [HW-1:0] A_END  = HW'(ACT_START + ACT_LEN);

    logic [HW-1:0] hcount_q, hcount_d, hoff, wid_a, wid_b;
    logic [9:0]    line_q, line_d, line_num_q;
    logic [2:0]    rgb_q, rgb_d;
    logic          csync_q, csync_d, active_q, active_d, field_q, slot_b, act_line;

    always_comb begin
        hcount_d = (hcount_q == H_LAST) ? '0 : hcount_q + 1'b1;
        line_d   = (hcount_q != H_LAST) ? line_q : (line_q == 10'd625) ? 10'd1 : line_q + 10'd1;
        // Pulse width of each half-line slot; zero width means no pulse in that slot.
        wid_a    = (line_q <= 10'd3 || line_q == 10'd314 || line_q == 10'd315) ? W_B
                 : (line_q <= 10'd5 || (line_q >= 10'd311 && line_q <= 10'd318) || line_q >= 10'd624) ? W_E
                 : W_N;
        wid_b    = (line_q <= 10'd2 || (line_q >= 10'd313 && line_q <= 10'd315)) ? W_B
                 : (line_q <= 10'd5 || (line_q >= 10'd311 && line_q <= 10'd317) || line_q >= 10'd623) ? W_E
                 : '0;
        slot_b   = hcount_q >= H_HALF;
        hoff     = slot_b ? hcount_q - H_HALF : hcount_q;
        csync_d  = hoff >= (slot_b ? wid_b : wid_a);
        act_line = (line_q >= 10'd23 && line_q <= 10'd310) || (line_q >= 10'd336 && line_q <= 10'd623);
        active_d = act_line && hcount_q >= A_BEG && hcount_q < A_END;
        rgb_d    = {vid.red_in, vid.green_in, vid.blue_in} & {3{active_d}};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_q   <= '0;
            line_q     <= 10'd1;
            csync_q    <= 1'b1;
            rgb_q      <= 3'b000;
            active_q   <= 1'b0;
            field_q    <= 1'b1;
            line_num_q <= 10'd1;
        end else begin
            hcount_q   <= hcount_d;
            line_q     <= line_d;
            csync_q    <= csync_d;
            rgb_q      <= rgb_d;
            active_q   <= active_d;
            field_q    <= line_q <= 10'd312;
            line_num_q <= line_q;
        end
    end

    assign vid.csync_out  = csync_q;
    assign vid.red_out    = rgb_q[2];
    assign vid.green_out  = rgb_q[1];
    assign vid.blue_out   = rgb_q[0];
    assign vid.active_out = active_q;
    assign vid.field_odd  = field_q;
    assign vid.line_num   = line_num_q;
endmodule
